// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Four-channel push-button conditioner (R, L, U, D). Each raw, asynchronous,
// bouncing pad is passed through a 2-flop synchroniser and then a per-channel
// debounce FSM. The FSM produces a clean level and one-cycle press/release
// strobes, so downstream edge detectors see exactly one press and one release
// per physical actuation.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   reset          asynchronous, active-high reset
//   btnR/L/U/D     raw button pads (asynchronous, active-high)
//   btnR/L/U/D_db  debounced levels
//   press_pulse    one-cycle strobe on an accepted 0->1 change, bits {D,U,L,R}
//   release_pulse  one-cycle strobe on an accepted 1->0 change, bits {D,U,L,R}
//
// Parameters:
//   DEBOUNCE_COUNT consecutive stable synchronised cycles needed before a level
//                  change is accepted (legal range 2 .. 2**CNT_WIDTH-1)
//   CNT_WIDTH      width of each per-channel stability counter
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_COUNT = 1000000,
  parameter int CNT_WIDTH      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnR,
  input  logic       btnL,
  input  logic       btnU,
  input  logic       btnD,
  output logic       btnR_db,
  output logic       btnL_db,
  output logic       btnU_db,
  output logic       btnD_db,
  output logic [3:0] press_pulse,
  output logic [3:0] release_pulse
);

  typedef enum logic [1:0] {
    LOW       = 2'b00,
    WAIT_HIGH = 2'b01,
    HIGH      = 2'b10,
    WAIT_LOW  = 2'b11
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_TERM = CNT_WIDTH'(DEBOUNCE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  logic [3:0]           raw;
  logic [3:0]           sync_p0;
  logic [3:0]           sync_p1;
  state_t               state     [4];
  state_t               state_nxt [4];
  logic [CNT_WIDTH-1:0] cnt       [4];
  logic [CNT_WIDTH-1:0] cnt_nxt   [4];
  logic [3:0]           press_nxt;
  logic [3:0]           release_nxt;
  logic [3:0]           db;

  assign raw = {btnD, btnU, btnL, btnR};

  // Stage p0/p1: two-flop synchroniser; only sync_p1 is used by the FSMs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 4'b0000;
      sync_p1 <= 4'b0000;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounce FSM state, counters and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= LOW;
        cnt[i]   <= CNT_ZERO;
      end
      press_pulse   <= 4'b0000;
      release_pulse <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  // Next-state logic. The counter counts synchronised samples that disagree
  // with the current level; entering a WAIT state already counts the first
  // one, so the change is accepted on the DEBOUNCE_COUNT-th agreeing sample.
  always_comb begin
    press_nxt   = 4'b0000;
    release_nxt = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = CNT_ZERO;
      case (state[i])
        LOW: begin
          if (sync_p1[i]) begin
            state_nxt[i] = WAIT_HIGH;
            cnt_nxt[i]   = CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          if (!sync_p1[i]) begin
            state_nxt[i] = LOW;
          end else if (cnt[i] == CNT_TERM) begin
            state_nxt[i] = HIGH;
            press_nxt[i] = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_ONE;
          end
        end
        HIGH: begin
          if (!sync_p1[i]) begin
            state_nxt[i] = WAIT_LOW;
            cnt_nxt[i]   = CNT_ONE;
          end
        end
        WAIT_LOW: begin
          if (sync_p1[i]) begin
            state_nxt[i] = HIGH;
          end else if (cnt[i] == CNT_TERM) begin
            state_nxt[i]   = LOW;
            release_nxt[i] = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_ONE;
          end
        end
        default: begin
          state_nxt[i] = LOW;
        end
      endcase
    end
  end

  // The level is decoded straight from the state register, so it changes on
  // the same edge as the corresponding strobe.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db[i] = (state[i] == HIGH) || (state[i] == WAIT_LOW);
    end
  end

  assign btnR_db = db[0];
  assign btnL_db = db[1];
  assign btnU_db = db[2];
  assign btnD_db = db[3];

endmodule
